// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of the UART-side APB initiator.
// master: the apb_master view; slave: the command source / APB fabric view.
interface apb_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// APB initiator: one command -> SETUP/ACCESS transfer -> held response.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles without pready.
module apb_master #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         pclk,
    input  logic         preset,
    apb_master_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_done;
    logic              w_abort;

`ifdef APB_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset)
            r_wait_cnt <= '0;
        else if (r_state == S_SETUP)
            r_wait_cnt <= '0;
        else if (r_state == S_ACCESS && !bus.pready)
            r_wait_cnt <= r_wait_cnt + 8'd1;
    end

    // pready on the limit cycle wins: abort only while the slave is still stalling
    assign w_abort = (r_state == S_ACCESS) && !bus.pready &&
                     (r_wait_cnt == 8'(TIMEOUT - 1));
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_abort = 1'b0;
`endif

    assign w_done = (r_state == S_ACCESS) && bus.pready;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.cmd_valid) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_done || w_abort) w_next = S_RESP;
            S_RESP:   if (bus.rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (r_state == S_IDLE);
        bus.psel      = (r_state == S_SETUP) || (r_state == S_ACCESS);
        bus.penable   = (r_state == S_ACCESS);
        bus.rsp_valid = (r_state == S_RESP);
    end

    // Address/data are latched only on acceptance and stay put through IDLE
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (r_state == S_IDLE && bus.cmd_valid) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_wdata;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_done) begin
            r_err   <= bus.pslverr;
            r_rdata <= r_pwrite ? '0 : bus.prdata;
        end else if (w_abort) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
        end
    end

    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed table, randomized transfers against a
// transaction-level model, mid-transfer reset and (optionally) timeout abort.
module tb_apb_master;
    localparam int TIMEOUT = 16;

    logic pclk = 1'b0;
    logic preset;
    always #5 pclk = ~pclk;

    apb_master_if bus ();

    apb_master #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus.master)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       wr;
        logic [3:0] a;
        logic [7:0] wd;
        int         waits;
        logic [7:0] rd;
        logic       se;
        int         rdly;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Entered just after a rising edge with the DUT idle; leaves the same way.
    task automatic do_txn(input logic wr, input logic [3:0] a, input logic [7:0] wd,
                          input int waits, input logic [7:0] rd, input logic se,
                          input int rdly, input logic [7:0] exp_rd, input logic exp_err,
                          input string nm);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bus.pready    = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge pclk);
        chk({nm, ".idle_ready"}, bus.cmd_ready, 1);
        step();
        // command source keeps valid high with different payload: must be ignored
        bus.cmd_addr  = ~a;
        bus.cmd_wdata = ~wd;
        bus.cmd_write = ~wr;
        @(negedge pclk);
        chk({nm, ".setup_sel_en_rdy"}, {bus.psel, bus.penable, bus.cmd_ready}, 3'b100);
        step();
        for (int i = 0; i <= waits; i++) begin
            bus.pready  = (i == waits);
            bus.prdata  = (i == waits) ? rd : 8'($urandom);
            bus.pslverr = (i == waits) ? se : 1'($urandom);
            @(negedge pclk);
            chk({nm, ".access_sel_en"}, {bus.psel, bus.penable, bus.rsp_valid}, 3'b110);
            chk({nm, ".access_addr"}, bus.paddr, a);
            chk({nm, ".access_wr_wdata"}, {bus.pwrite, bus.pwdata}, {wr, wd});
            step();
        end
        bus.pready    = 1'b0;
        bus.cmd_valid = 1'b0;
        for (int j = 0; j <= rdly; j++) begin
            bus.rsp_ready = (j == rdly);
            @(negedge pclk);
            chk({nm, ".resp_valid"}, bus.rsp_valid, 1);
            chk({nm, ".resp_rdata"}, bus.rsp_rdata, exp_rd);
            chk({nm, ".resp_err"}, bus.rsp_err, exp_err);
            chk({nm, ".resp_sel_en_rdy"}, {bus.psel, bus.penable, bus.cmd_ready}, 3'b000);
            step();
        end
        bus.rsp_ready = 1'b0;
        @(negedge pclk);
        chk({nm, ".back_idle"}, {bus.cmd_ready, bus.rsp_valid}, 2'b10);
        chk({nm, ".held_rdata_addr"}, {bus.rsp_rdata, bus.paddr}, {exp_rd, a});
        step();
    endtask

    initial begin
        int n;
        vec_t v;
        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        vt[0] = '{1'b1, 4'h3, 8'hA5, 0, 8'h77, 1'b0, 0, 8'h00, 1'b0};
        vt[1] = '{1'b0, 4'h7, 8'h00, 2, 8'h5C, 1'b0, 0, 8'h5C, 1'b0};
        vt[2] = '{1'b0, 4'h1, 8'h11, 0, 8'h3C, 1'b1, 0, 8'h3C, 1'b1};
        vt[3] = '{1'b1, 4'h2, 8'h22, 0, 8'h99, 1'b0, 0, 8'h00, 1'b0};
        vt[4] = '{1'b0, 4'hF, 8'h00, 1, 8'hFF, 1'b0, 3, 8'hFF, 1'b0};
        vt[5] = '{1'b1, 4'h0, 8'hFF, 3, 8'h81, 1'b1, 1, 8'h00, 1'b1};

        @(negedge pclk);
        chk("reset.sel_en_valid", {bus.psel, bus.penable, bus.rsp_valid}, 3'b000);
        chk("reset.rdata_err", {bus.rsp_rdata, bus.rsp_err}, 9'h000);
        chk("reset.pwrite_addr_wdata", {bus.pwrite, bus.paddr, bus.pwdata}, 13'h0);
        step();
        preset = 1'b0;
        @(negedge pclk);
        chk("reset.cmd_ready", bus.cmd_ready, 1);
        step();

        foreach (vt[k])
            do_txn(vt[k].wr, vt[k].a, vt[k].wd, vt[k].waits, vt[k].rd, vt[k].se,
                   vt[k].rdly, vt[k].exp_rd, vt[k].exp_err, $sformatf("vec%0d", k));

        // Reference model: reads return prdata, writes return 0, err mirrors pslverr
        for (int r = 0; r < 20; r++) begin
            v.wr      = 1'($urandom);
            v.a       = 4'($urandom);
            v.wd      = 8'($urandom);
            v.waits   = $urandom_range(0, 4);
            v.rd      = 8'($urandom);
            v.se      = 1'($urandom);
            v.rdly    = $urandom_range(0, 3);
            v.exp_rd  = v.wr ? 8'h00 : v.rd;
            v.exp_err = v.se;
            do_txn(v.wr, v.a, v.wd, v.waits, v.rd, v.se, v.rdly, v.exp_rd, v.exp_err,
                   $sformatf("rnd%0d", r));
        end

        // Reset while ACCESS is stalled
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'h5;
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        @(negedge pclk);
        chk("midrst.pre_access", {bus.psel, bus.penable}, 2'b11);
        #1 preset = 1'b1;
        #1;
        chk("midrst.sel_en_valid", {bus.psel, bus.penable, bus.rsp_valid}, 3'b000);
        chk("midrst.rdata_err", {bus.rsp_rdata, bus.rsp_err}, 9'h000);
        @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        chk("midrst.after_ready", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
        step();
        do_txn(1'b0, 4'h6, 8'h00, 1, 8'hC3, 1'b0, 0, 8'hC3, 1'b0, "postrst");

`ifdef APB_TIMEOUT_EN
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'h9;
        bus.prdata    = 8'hEE;
        bus.pready    = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        step();
        n = 0;
        while (n < 40) begin
            @(negedge pclk);
            if (!(bus.psel && bus.penable)) break;
            n++;
            @(posedge pclk);
            #1;
        end
        chk("tmo.access_cycles", n, TIMEOUT);
        chk("tmo.resp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 1'b1, 8'h00});
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        do_txn(1'b0, 4'h9, 8'h00, TIMEOUT - 1, 8'h42, 1'b0, 0, 8'h42, 1'b0, "tmo_limit_ready");
`else
        n = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
